vco_phase_decoder: RTL
======================

# vco_phase_decoder

Digital back end of the VCO-based ADC. Samples the ring-oscillator phase vector `p` from `vco_r100` once per system clock and decodes it to a ring-state index. It accumulates the modulo phase advance over an oversampling frame and hands one conversion result per frame to the downstream consumer over a valid/ready handshake. It also drives the VCO's active-low `enb`.

## Interface
- `PHASE_WIDTH`, 11: number of ring taps N, odd; the ring has 2N states.
- `OSR_LOG2`, 9: frame length is 2^OSR_LOG2 phase differences (512).
- `IDX_WIDTH`, 5: width of ring index and per-sample difference; must satisfy 2^IDX_WIDTH ≥ 2N.
- `OUT_WIDTH`, 14: IDX_WIDTH+OSR_LOG2, width of the frame sum.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: conversion enable from control logic.
- `p` in PHASE_WIDTH: raw ring phases, asynchronous to `clk`.
- `enb` out 1: VCO enable, active-low, drives `vco_r100.enb`.
- `out_data` out OUT_WIDTH: frame result.
- `out_valid` out 1: `out_data` holds an unconsumed result.
- `out_ready` in 1: consumer accepts the result.
- `ovf` out 1: sticky flag set when a frame result was dropped; cleared only by `rst` or `en` rising.
- `err_cnt` out 8: count of invalid phase codes, saturating; see Configuration.

## Operation
- Sync: `p` passes through a 2-flop synchronizer, then the index decoder.
- Ring code for state k: for 0 ≤ k ≤ N, the low k bits are 1 and the rest 0. For N < k < 2N, the low k−N bits are 0 and the rest 1.
- Decode (bubble tolerant): pc = popcount(p_sync). If p_sync[0]=1, idx = pc. Otherwise idx = (2N − pc) mod 2N.
- Difference: d = (idx − idx_prev) mod 2N, range 0..2N−1, IDX_WIDTH bits, unsigned. idx_prev then takes the value of idx.
- FSM states:
  - IDLE → PRIME when `en`=1.
  - PRIME lasts 3 cycles. `enb`=0 and the synchronizer flushes. In the last PRIME cycle, idx_prev is loaded and no difference is taken. PRIME → RUN.
  - RUN → IDLE when `en`=0.
  - Any state → IDLE on `rst`.
- RUN: each cycle, acc += d and the frame counter increments. When the counter reaches 2^OSR_LOG2−1, the frame closes: the result is acc+d, acc is cleared, and the counter wraps to 0. The difference sequence continues without a gap.
- The accumulator is OUT_WIDTH bits. The maximum sum is (2N−1)·2^OSR_LOG2, which fits, so there is no overflow.
- Output register: one entry.
  - At frame close, if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, the register loads and out_valid=1.
  - Otherwise the new result is dropped, the held value is kept, and `ovf` is set.
- Handshake: a transfer occurs on a cycle with out_valid=1 and out_ready=1. With no new load that cycle, out_valid clears. out_data is stable while out_valid=1 and out_ready=0.
- `en` falling: the partial frame is discarded (acc and counter cleared) and `enb` returns to 1. A held result stays valid until it is taken.
- `en` rising clears `ovf`.

## Timing
- Reset values: `enb`=1, `out_valid`=0, `out_data`=0, `ovf`=0, `err_cnt`=0, state IDLE, acc=0, counter=0, idx_prev=0.
- `enb` is registered. It goes low the cycle after `en` is sampled high, and high the cycle after `en` is sampled low.
- Input-to-decoder latency: 2 cycles (synchronizer).
- First `out_valid`: 1 (IDLE→PRIME) + 3 (PRIME) + 512 RUN cycles after `en` is sampled high. After that, one result every 512 cycles.
- out_valid rises the cycle after frame close. A consumer that is always ready sees a single-cycle pulse.

## Configuration
- `VCO_DEC_ERR_EN` defined:
  - In RUN, a code that is neither ones-low nor ones-high contiguous (per the ring code) is invalid.
  - Each invalid code increments `err_cnt`, which saturates at 255.
  - The decoded idx from the popcount rule is still used.
- Undefined: no checker logic is built and `err_cnt` is tied to 0.

## Structure
- Package `vco_adc_pkg`:
  - `RING_STATES(N)`=2N function.
  - FSM state enum {IDLE, PRIME, RUN}.
  - PRIME length constant 3.
  - Default widths.
- Sub-module `vco_phase_to_index`: combinational popcount decode plus validity flag, parameterized by PHASE_WIDTH.

## Test plan
- Static code k=5 through a full frame → out_data=0, ovf=0.
- Ring advancing 1 state/cycle, wrapping 21→0 → each d=1, out_data=512 per frame, first out_valid on cycle 516 after `en`.
- Idx jump 20→1 → d=3 (wrap-around). Constant advance of 7/cycle → out_data=3584.
- out_ready held low across two frame closes → first result held unchanged, second dropped, ovf=1. Later out_ready=1 → single transfer, out_valid=0.
- `rst` asserted mid-frame (cycle 200 of RUN), and separately `en` dropped mid-frame → all outputs at reset values / enb=1, no out_valid from the partial frame. Restarting produces a full 512-sample frame.
- With VCO_DEC_ERR_EN, inject code 0b00000000101 three times → err_cnt=3, idx=2 each time. Without the macro → err_cnt=0.

Source files
------------

// File: rtl/vco_adc_pkg.sv
// Shared types and default sizing for the VCO ADC digital back end.
package vco_adc_pkg;

    localparam int unsigned PHASE_WIDTH_DEF = 11;
    localparam int unsigned OSR_LOG2_DEF    = 9;
    localparam int unsigned IDX_WIDTH_DEF   = 5;
    localparam int unsigned OUT_WIDTH_DEF   = IDX_WIDTH_DEF + OSR_LOG2_DEF;

    localparam int unsigned PRIME_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    function automatic int unsigned RING_STATES(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/vco_phase_to_index.sv
// Bubble-tolerant popcount decode of a ring phase vector to a state index.
// With VCO_DEC_ERR_EN defined, also flags codes that are not a contiguous ring code.
module vco_phase_to_index
    import vco_adc_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DEF
) (
    input  logic [PHASE_WIDTH-1:0] i_p,
    output logic [IDX_WIDTH-1:0]   o_idx
`ifdef VCO_DEC_ERR_EN
    ,
    output logic                   o_valid
`endif
);

    // When 2N equals 2^IDX_WIDTH this truncates to zero, which is still correct modulo arithmetic.
    localparam logic [IDX_WIDTH-1:0] RING = IDX_WIDTH'(RING_STATES(PHASE_WIDTH));

    logic [IDX_WIDTH-1:0] w_pc;

    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < PHASE_WIDTH; i++) begin
            w_pc = w_pc + IDX_WIDTH'(i_p[i]);
        end
    end

    always_comb begin
        o_idx = w_pc;
        if (!i_p[0]) begin
            o_idx = (w_pc == '0) ? '0 : RING - w_pc;
        end
    end

`ifdef VCO_DEC_ERR_EN
    logic [PHASE_WIDTH-1:0] w_inv;
    logic                   w_ones_low;
    logic                   w_ones_high;

    // x is of the form 0..01..1 exactly when x & (x+1) is zero.
    assign w_inv       = ~i_p;
    assign w_ones_low  = ((i_p & (i_p + PHASE_WIDTH'(1))) == '0);
    assign w_ones_high = ((w_inv & (w_inv + PHASE_WIDTH'(1))) == '0);
    assign o_valid     = w_ones_low | w_ones_high;
`endif

endmodule

// File: rtl/vco_phase_decoder.sv
// VCO ADC back end: phase sync, ring decode, frame accumulation, one-entry result register.
// Define VCO_DEC_ERR_EN to build the saturating invalid-code counter on o_err_cnt.
module vco_phase_decoder
    import vco_adc_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned OSR_LOG2    = OSR_LOG2_DEF,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH   = IDX_WIDTH + OSR_LOG2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [PHASE_WIDTH-1:0] i_p,
    output logic                   o_enb,
    output logic [OUT_WIDTH-1:0]   o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_ovf,
    output logic [7:0]             o_err_cnt
);

    localparam logic [IDX_WIDTH-1:0] RING       = IDX_WIDTH'(RING_STATES(PHASE_WIDTH));
    localparam logic [1:0]           PRIME_LAST = 2'(PRIME_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_prime_cnt;
    logic [PHASE_WIDTH-1:0] r_sync1;
    logic [PHASE_WIDTH-1:0] r_sync2;
    logic [IDX_WIDTH-1:0]   w_idx;
    logic [IDX_WIDTH-1:0]   r_idx_prev;
    logic [IDX_WIDTH-1:0]   w_diff;
    logic [OUT_WIDTH-1:0]   r_acc;
    logic [OUT_WIDTH-1:0]   w_sum;
    logic [OSR_LOG2-1:0]    r_frame_cnt;
    logic                   r_enb;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_valid;
    logic                   r_ovf;
    logic                   w_start;
    logic                   w_load_prev;
    logic                   w_run_step;
    logic                   w_stop;
    logic                   w_close;
`ifdef VCO_DEC_ERR_EN
    logic                   w_code_ok;
    logic [7:0]             r_err_cnt;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_p;
            r_sync2 <= r_sync1;
        end
    end

    vco_phase_to_index #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_phase_to_index (
        .i_p    (r_sync2),
        .o_idx  (w_idx)
`ifdef VCO_DEC_ERR_EN
        ,
        .o_valid(w_code_ok)
`endif
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_prime_cnt <= '0;
            r_enb       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_prime_cnt <= (r_state == PRIME) ? r_prime_cnt + 2'd1 : '0;
            r_enb       <= (w_state_nxt == IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load_prev = 1'b0;
        w_run_step  = 1'b0;
        w_stop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_state_nxt = PRIME;
                    w_start     = 1'b1;
                end
            end
            PRIME: begin
                if (r_prime_cnt == PRIME_LAST) begin
                    w_state_nxt = RUN;
                    w_load_prev = 1'b1;
                end
            end
            RUN: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_run_step  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Modulo-2N difference: add the ring size back when the subtraction wraps.
    always_comb begin
        w_diff = w_idx - r_idx_prev;
        if (w_idx < r_idx_prev) begin
            w_diff = w_diff + RING;
        end
    end

    assign w_sum   = r_acc + OUT_WIDTH'(w_diff);
    assign w_close = w_run_step && (r_frame_cnt == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx_prev  <= '0;
            r_acc       <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_load_prev || w_run_step) begin
                r_idx_prev <= w_idx;
            end
            if (w_run_step) begin
                r_frame_cnt <= r_frame_cnt + OSR_LOG2'(1);
                r_acc       <= w_close ? '0 : w_sum;
            end else if (w_stop) begin
                r_frame_cnt <= '0;
                r_acc       <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_close) begin
                if (!r_out_valid || i_out_ready) begin
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_start) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef VCO_DEC_ERR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (w_run_step && !w_code_ok && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = '0;
`endif

    assign o_enb       = r_enb;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_ovf       = r_ovf;

endmodule
